// File: rtl/rng_pkg.sv
// rng_pkg: shared deck size, card type and deal-state encoding for the card dealer
package rng_pkg;
    localparam int DECK_SIZE = 52;
    typedef logic [7:0] card_t;
    typedef enum logic [1:0] {IDLE, SPIN, HUNT, DELIVER} deal_state_t;
endpackage

// File: rtl/rng_deck_tracker.sv
// rng_deck_tracker: dealt-card mask with membership test, mark and clear, plus dealt count and empty flag
module rng_deck_tracker
    import rng_pkg::*;
#(
    parameter int DECK_SIZE = rng_pkg::DECK_SIZE
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       mark_i,
    input  card_t      mark_card_i,
    input  card_t      test_card_i,
    output logic       test_free_o,
    output logic [5:0] deal_count_o,
    output logic       empty_o
);
    localparam logic [DECK_SIZE-1:0] ONE = {{(DECK_SIZE-1){1'b0}}, 1'b1};
    logic [DECK_SIZE-1:0] mask;
    // card c lives at mask bit c-1; card 0 underflows and is excluded by the range test
    assign test_free_o = test_card_i >= 8'd1 && test_card_i <= 8'(DECK_SIZE) &&
                         !(|(mask & (ONE << (test_card_i - 8'd1))));
    assign empty_o = deal_count_o == 6'(DECK_SIZE);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mask <= '0;
            deal_count_o <= '0;
        end else if (clear_i) begin
            mask <= '0;
            deal_count_o <= '0;
        end else if (mark_i) begin
            mask <= mask | (ONE << (mark_card_i - 8'd1));
            deal_count_o <= deal_count_o + 6'd1;
        end
    end
endmodule

// File: rtl/rng_deal_controller.sv
// rng_deal_controller: deals unique cards by sampling a free-running counter after a spin delay
// Optional RNG_DEAL_STATS_EN adds last_hunt_o, the rejected-sample count of the latest card.
module rng_deal_controller
    import rng_pkg::*;
#(
    parameter int DECK_SIZE   = rng_pkg::DECK_SIZE,
    parameter int SPIN_CYCLES = 7
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       draw_req_i,
    input  logic       shuffle_i,
    input  logic [7:0] counter_val_i,
    output logic       counter_run_o,
    output logic [7:0] card_o,
    output logic       card_valid_o,
    input  logic       card_ready_i,
    output logic [5:0] deal_count_o,
    output logic       deck_empty_o,
    output logic       busy_o
`ifdef RNG_DEAL_STATS_EN
    ,
    output logic [7:0] last_hunt_o
`endif
);
    deal_state_t state, state_n;
    card_t spin_cnt;
    logic clear, mark, free;
    rng_deck_tracker #(.DECK_SIZE(DECK_SIZE)) u_deck (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear),
        .mark_i      (mark),
        .mark_card_i (counter_val_i),
        .test_card_i (counter_val_i),
        .test_free_o (free),
        .deal_count_o(deal_count_o),
        .empty_o     (deck_empty_o)
    );
    always_comb begin
        state_n = state;
        clear = 1'b0;
        mark = 1'b0;
        case (state)
            IDLE: begin
                clear = shuffle_i;
                state_n = (draw_req_i && !shuffle_i && !deck_empty_o) ? SPIN : IDLE;
            end
            SPIN: state_n = spin_cnt == '0 ? HUNT : SPIN;
            HUNT: begin
                mark = free;
                state_n = free ? DELIVER : HUNT;
            end
            DELIVER: state_n = card_ready_i ? IDLE : DELIVER;
            default: state_n = IDLE;
        endcase
    end
    assign counter_run_o = state == SPIN || state == HUNT;
    assign card_valid_o = state == DELIVER;
    assign busy_o = state != IDLE;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            spin_cnt <= '0;
            card_o <= '0;
        end else begin
            state <= state_n;
            spin_cnt <= state == IDLE ? 8'(SPIN_CYCLES - 1) : state == SPIN ? spin_cnt - 8'd1 : spin_cnt;
            if (mark)
                card_o <= counter_val_i;
        end
    end
`ifdef RNG_DEAL_STATS_EN
    card_t hunt_cnt;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hunt_cnt <= '0;
            last_hunt_o <= '0;
        end else begin
            hunt_cnt <= state == IDLE ? 8'd0 : (state == HUNT && !free) ? hunt_cnt + 8'd1 : hunt_cnt;
            if (mark)
                last_hunt_o <= hunt_cnt;
        end
    end
`endif
endmodule
